fx3_burst_reader: RTL and testbench

- Read-side consumer of the camera dual-clock data FIFO. Runs entirely in the FX3 PCLK domain.
- Waits until the FIFO holds a full burst and the FX3 slave-FIFO watermark flag reports space. Then pops BURST_LEN 16-bit words and drives them onto the FX3 GPIF slave-FIFO write bus.
- On request, flushes the FIFO remainder as a short packet via PKTEND, or as a ZLP when the FIFO is empty.

---
 rtl/fx3_pkg.sv | 20 ++
 rtl/fx3_burst_reader.sv | 153 +++++++++++++++
 tb/tb_fx3_burst_reader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fx3_pkg.sv
// Shared constants and state encoding for the FX3 slave-FIFO burst reader.
package fx3_pkg;

    localparam int DATA_W = 16;

    // FX3 GPIF strobes are active-low
    localparam logic SLWR_ACTIVE   = 1'b0;
    localparam logic SLWR_IDLE     = 1'b1;
    localparam logic PKTEND_ACTIVE = 1'b0;
    localparam logic PKTEND_IDLE   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        BURST,
        DRAIN,
        PKTEND,
        GAP
    } state_t;

endpackage

// File: rtl/fx3_burst_reader.sv
// Pops bursts from the camera read-side FIFO and writes them onto the FX3
// GPIF slave-FIFO bus; on request commits the remainder as a short packet
// or a zero-length packet.
module fx3_burst_reader
    import fx3_pkg::*;
#(
    parameter int DATA_W    = fx3_pkg::DATA_W,
    parameter int ADDR_W    = 10,
    parameter int BURST_LEN = 512,
    parameter int GAP_CYC   = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fifo_rdusedw,
    input  logic              fifo_rdempty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rdreq,
    input  logic              fx3_flag,
    output logic              fx3_slwr_n,
    output logic              fx3_pktend_n,
    output logic [DATA_W-1:0] fx3_data,
    input  logic              flush_req,
    output logic              busy
);

    localparam int WAIT_W = $clog2(GAP_CYC + 1) + 1;
    localparam logic [ADDR_W-1:0] FULL_LEN   = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(1);
    localparam logic [WAIT_W-1:0] DRAIN_LAST = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(GAP_CYC - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] word_cnt;
    logic [ADDR_W-1:0] load_len;
    logic              load_en;
    logic              load_short;
    logic              short_pkt;
    logic              flush_pend;
    logic [WAIT_W-1:0] st_cyc;
    logic              rd_d1;

    // State register plus a per-state cycle counter used by DRAIN and GAP
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            st_cyc <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                st_cyc <= '0;
            end else if (state == DRAIN || state == GAP) begin
                st_cyc <= st_cyc + WAIT_W'(1);
            end
        end
    end

    // Next-state decision; a full burst wins over a flush, and both wait for the watermark
    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        load_len   = FULL_LEN;
        load_short = 1'b0;
        unique case (state)
            IDLE: begin
                if (fx3_flag) begin
                    if (fifo_rdusedw >= FULL_LEN) begin
                        state_next = BURST;
                        load_en    = 1'b1;
                    end else if (flush_pend && fifo_rdusedw != '0) begin
                        state_next = BURST;
                        load_en    = 1'b1;
                        load_len   = fifo_rdusedw;
                        load_short = 1'b1;
                    end else if (flush_pend) begin
                        state_next = PKTEND;
                    end
                end
            end
            BURST: begin
                if (fifo_rdreq && word_cnt == LAST_WORD) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (st_cyc == DRAIN_LAST) begin
                    state_next = short_pkt ? PKTEND : GAP;
                end
            end
            PKTEND: begin
                state_next = GAP;
            end
            GAP: begin
                if (st_cyc == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; pops stall rather than underflow an empty FIFO
    always_comb begin
        fifo_rdreq   = (state == BURST) && !fifo_rdempty;
        fx3_pktend_n = (state == PKTEND) ? PKTEND_ACTIVE : PKTEND_IDLE;
        busy         = (state != IDLE) || flush_pend;
    end

    // Burst word counter, short-packet marker and sticky flush request
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt   <= '0;
            short_pkt  <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            if (load_en) begin
                word_cnt <= load_len;
            end else if (fifo_rdreq) begin
                word_cnt <= word_cnt - LAST_WORD;
            end

            if (load_en) begin
                short_pkt <= load_short;
            end else if (state == PKTEND) begin
                short_pkt <= 1'b0;
            end

            if (flush_req) begin
                flush_pend <= 1'b1;
            end else if (state == PKTEND) begin
                flush_pend <= 1'b0;
            end
        end
    end

    // Two-stage read pipeline: FIFO data arrives one cycle after rdreq, then drives the bus with slwr
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_d1      <= 1'b0;
            fx3_slwr_n <= SLWR_IDLE;
            fx3_data   <= '0;
        end else begin
            rd_d1      <= fifo_rdreq;
            fx3_slwr_n <= rd_d1 ? SLWR_ACTIVE : SLWR_IDLE;
            if (rd_d1) begin
                fx3_data <= fifo_q;
            end
        end
    end

endmodule

// File: tb/tb_fx3_burst_reader.sv
// Directed bench for fx3_burst_reader with a behavioural non-showahead FIFO
// that supplies an incrementing word sequence.
module tb_fx3_burst_reader;

    localparam int GAP_CYC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  fifo_rdusedw;
    logic        fifo_rdempty;
    logic [15:0] fifo_q;
    logic        fifo_rdreq;
    logic        fx3_flag;
    logic        fx3_slwr_n;
    logic        fx3_pktend_n;
    logic [15:0] fx3_data;
    logic        flush_req;
    logic        busy;

    int num_checks = 0;
    int num_errors = 0;
    int cyc = 0;

    // FIFO model state
    logic [15:0] q[$];
    int push_total = 0;
    int pushed = 0;

    // Monitor state
    int rdreq_count = 0;
    int slwr_count = 0;
    int pktend_count = 0;
    int rdreq_start_cyc = 0;
    int slwr_start_cyc = 0;
    int last_slwr_cyc = 0;
    int pktend_cyc = 0;
    int idle_cyc = 0;
    logic [15:0] exp_word = 16'd0;
    logic prev_rdreq = 1'b0;
    logic prev_slwr_n = 1'b1;

    fx3_burst_reader #(
        .DATA_W(16),
        .ADDR_W(10),
        .BURST_LEN(512),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_rdusedw(fifo_rdusedw),
        .fifo_rdempty(fifo_rdempty),
        .fifo_q(fifo_q),
        .fifo_rdreq(fifo_rdreq),
        .fx3_flag(fx3_flag),
        .fx3_slwr_n(fx3_slwr_n),
        .fx3_pktend_n(fx3_pktend_n),
        .fx3_data(fx3_data),
        .flush_req(flush_req),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycle index, advanced on each active edge
    always @(posedge clk) cyc <= cyc + 1;

    // Non-showahead FIFO: pop on rdreq, data valid next cycle, flags registered
    always @(posedge clk) begin
        logic [15:0] w;
        if (fifo_rdreq && q.size() > 0) begin
            w = q.pop_front();
            fifo_q <= w;
        end
        while (pushed < push_total) begin
            q.push_back(16'(pushed));
            pushed++;
        end
        fifo_rdusedw <= (q.size() > 1023) ? 10'd1023 : 10'(q.size());
        fifo_rdempty <= (q.size() == 0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Bus monitor sampled on the inactive edge
    always @(negedge clk) begin
        if (fifo_rdreq === 1'b1) begin
            rdreq_count++;
            if (!prev_rdreq) rdreq_start_cyc = cyc;
            checkOutput("rdreq_while_empty", 32'(fifo_rdempty), 32'd0);
        end
        if (fx3_slwr_n === 1'b0) begin
            checkOutput("slwr_data", 32'(fx3_data), 32'(exp_word));
            exp_word++;
            slwr_count++;
            last_slwr_cyc = cyc;
            if (prev_slwr_n === 1'b1) slwr_start_cyc = cyc;
        end
        if (fx3_pktend_n === 1'b0) begin
            pktend_count++;
            pktend_cyc = cyc;
            checkOutput("pktend_with_slwr", 32'(fx3_slwr_n), 32'd1);
        end
        prev_rdreq = (fifo_rdreq === 1'b1);
        prev_slwr_n = (fx3_slwr_n !== 1'b0);
    end

    task automatic applyStimulus(input int words, input logic flag);
        push_total += words;
        fx3_flag = flag;
    endtask

    task automatic pulseFlush();
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_busy_rise"}, 32'(busy), 32'd1);
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_busy_fall"}, 32'(busy), 32'd0);
        idle_cyc = cyc;
    endtask

    task automatic waitSlwr(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (slwr_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(slwr_count >= target), 32'd1);
    endtask

    initial begin
        int base_slwr;
        int base_pkt;
        int base_rdreq;
        int flag_cyc;

        rst = 1'b1;
        fx3_flag = 1'b0;
        flush_req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        checkOutput("rst_slwr_n", 32'(fx3_slwr_n), 32'd1);
        checkOutput("rst_pktend_n", 32'(fx3_pktend_n), 32'd1);
        checkOutput("rst_data", 32'(fx3_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Full burst out of 600 queued words
        applyStimulus(600, 1'b0);
        repeat (4) @(negedge clk);
        base_slwr = slwr_count;
        base_pkt = pktend_count;
        fx3_flag = 1'b1;
        waitDone("burst1", 2000);
        checkOutput("burst1_words", 32'(slwr_count - base_slwr), 32'd512);
        checkOutput("burst1_latency", 32'(slwr_start_cyc - rdreq_start_cyc), 32'd2);
        checkOutput("burst1_no_pktend", 32'(pktend_count - base_pkt), 32'd0);
        checkOutput("burst1_left", 32'(fifo_rdusedw), 32'd88);

        // Flush the 88-word remainder as a short packet
        base_slwr = slwr_count;
        base_pkt = pktend_count;
        pulseFlush();
        waitDone("short1", 2000);
        checkOutput("short1_words", 32'(slwr_count - base_slwr), 32'd88);
        checkOutput("short1_pktend", 32'(pktend_count - base_pkt), 32'd1);
        checkOutput("short1_pktend_gap", 32'(pktend_cyc - last_slwr_cyc), 32'd1);
        checkOutput("short1_empty", 32'(fifo_rdusedw), 32'd0);

        // Zero-length packet from an empty FIFO
        base_slwr = slwr_count;
        base_pkt = pktend_count;
        pulseFlush();
        waitDone("zlp", 200);
        checkOutput("zlp_words", 32'(slwr_count - base_slwr), 32'd0);
        checkOutput("zlp_pktend", 32'(pktend_count - base_pkt), 32'd1);
        checkOutput("zlp_gap_len", 32'(idle_cyc - pktend_cyc), 32'(GAP_CYC + 1));

        // Watermark held low, then raised; dropping it mid-burst must not stop the burst
        applyStimulus(1000, 1'b0);
        base_rdreq = rdreq_count;
        repeat (50) @(negedge clk);
        checkOutput("flag_low_no_rdreq", 32'(rdreq_count - base_rdreq), 32'd0);
        base_slwr = slwr_count;
        flag_cyc = cyc;
        fx3_flag = 1'b1;
        waitSlwr("flag_burst_progress", base_slwr + 200, 400);
        fx3_flag = 1'b0;
        waitDone("flag_burst", 2000);
        checkOutput("flag_burst_start", 32'(rdreq_start_cyc - flag_cyc), 32'd1);
        checkOutput("flag_burst_words", 32'(slwr_count - base_slwr), 32'd512);
        checkOutput("flag_burst_left", 32'(fifo_rdusedw), 32'd488);

        // 700 queued, flush arrives mid-burst: full burst, then 188-word short packet
        applyStimulus(212, 1'b0);
        repeat (3) @(negedge clk);
        base_slwr = slwr_count;
        base_pkt = pktend_count;
        fx3_flag = 1'b1;
        waitSlwr("midflush_progress", base_slwr + 50, 200);
        pulseFlush();
        waitDone("midflush", 4000);
        checkOutput("midflush_words", 32'(slwr_count - base_slwr), 32'd700);
        checkOutput("midflush_pktend", 32'(pktend_count - base_pkt), 32'd1);
        checkOutput("midflush_pktend_gap", 32'(pktend_cyc - last_slwr_cyc), 32'd1);
        checkOutput("midflush_empty", 32'(fifo_rdusedw), 32'd0);

        // Reset in the middle of a burst
        applyStimulus(1000, 1'b1);
        base_slwr = slwr_count;
        waitSlwr("rst_progress", base_slwr + 100, 400);
        rst = 1'b1;
        fx3_flag = 1'b0;
        @(negedge clk);
        checkOutput("midrst_slwr_n", 32'(fx3_slwr_n), 32'd1);
        checkOutput("midrst_rdreq", 32'(fifo_rdreq), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_data", 32'(fx3_data), 32'd0);
        rst = 1'b0;
        base_slwr = slwr_count;
        base_rdreq = rdreq_count;
        repeat (20) @(negedge clk);
        checkOutput("midrst_no_slwr", 32'(slwr_count - base_slwr), 32'd0);
        checkOutput("midrst_no_rdreq", 32'(rdreq_count - base_rdreq), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
